// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU float-format constants and types (used by itof and ftoi)
package fpu_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [FP_EXP_W-1:0] FP_EXP_BIAS = 8'd127;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX  = 8'd255;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    // Stage-1 register contents of the float-to-int converter
    typedef struct packed {
        logic        sign;
        logic [31:0] int_part;
        logic        guard;
        logic        sticky;
        logic        zero_c;
        logic        nan_c;
        logic        ovf_c;
        logic        min_c;
        logic        tiny_c;
    } ftoi_s1_t;

endpackage

// File: rtl/ftoi_round.sv
// rtl/ftoi_round.sv - combinational round, negate and saturate step of the float-to-int converter
module ftoi_round
    import fpu_pkg::*;
#(
    parameter int TIES_EVEN = 1
) (
    input  ftoi_s1_t    s1,
    output logic [31:0] result
);

    logic        inc;
    logic [31:0] mag;

    always_comb begin
        inc = s1.guard & (s1.sticky | ((TIES_EVEN != 0) ? s1.int_part[0] : 1'b1));
        // int_part never exceeds 0x7FFFFF80, so the increment cannot carry out
        mag = s1.int_part + {31'd0, inc};

        if (s1.nan_c) begin
            result = INT32_MAX;
        end else if (s1.ovf_c) begin
            result = s1.sign ? INT32_MIN : INT32_MAX;
        end else if (s1.min_c) begin
            result = INT32_MIN;
        end else if (s1.zero_c || s1.tiny_c) begin
            result = 32'd0;
        end else begin
            result = s1.sign ? (~mag + 32'd1) : mag;
        end
    end

endmodule

// File: rtl/ftoi_pipe.sv
// rtl/ftoi_pipe.sv - two-stage float32 to int32 converter; FTOI_FLAGS_EN adds out_invalid/out_inexact
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter int TIES_EVEN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef FTOI_FLAGS_EN
    ,
    output logic        out_invalid,
    output logic        out_inexact
`endif
);

    logic     s1_v;
    logic     s2_v;
    logic     adv1;
    logic     adv2;
    ftoi_s1_t s1_d;
    ftoi_s1_t s1_q;
    logic [31:0] rnd;

    fp32_t              f;
    logic signed [8:0]  e;
    logic [23:0]        m;
    logic [47:0]        rsh;
    logic [4:0]         sh_r;
    logic [2:0]         sh_l;

    assign adv2      = !s2_v || out_ready;
    assign adv1      = !s1_v || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_v;

    assign f = in_data;
    assign e = $signed({1'b0, f.exp}) - $signed({1'b0, FP_EXP_BIAS});
    assign m = {1'b1, f.mant};

    always_comb begin
        s1_d   = '0;
        rsh    = '0;
        sh_r   = '0;
        sh_l   = '0;

        s1_d.sign   = f.sign;
        s1_d.zero_c = (f.exp == '0);
        s1_d.nan_c  = (f.exp == FP_EXP_MAX) && (f.mant != '0);
        s1_d.min_c  = f.sign && (e == 9'sd31) && (f.mant == '0);
        s1_d.ovf_c  = ((f.exp == FP_EXP_MAX) && (f.mant == '0)) ||
                      ((e >= 9'sd31) && !s1_d.min_c);
        s1_d.tiny_c = (e <= -9'sd2);

        // Right-align with 24 extra fraction bits so guard and sticky fall out of one shift
        if ((e >= -9'sd1) && (e <= 9'sd23)) begin
            sh_r          = 5'(9'sd23 - e);
            rsh           = {m, 24'd0} >> sh_r;
            s1_d.int_part = {8'd0, rsh[47:24]};
            s1_d.guard    = rsh[23];
            s1_d.sticky   = |rsh[22:0];
        end else if ((e >= 9'sd24) && (e <= 9'sd30)) begin
            sh_l          = 3'(e - 9'sd23);
            s1_d.int_part = {8'd0, m} << sh_l;
        end
    end

    ftoi_round #(
        .TIES_EVEN (TIES_EVEN)
    ) u_round (
        .s1     (s1_q),
        .result (rnd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_q     <= '0;
            s2_v     <= 1'b0;
            out_data <= '0;
`ifdef FTOI_FLAGS_EN
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_data <= rnd;
`ifdef FTOI_FLAGS_EN
                    out_invalid <= s1_q.nan_c || s1_q.ovf_c;
                    out_inexact <= !(s1_q.nan_c || s1_q.ovf_c) &&
                                   (s1_q.guard || s1_q.sticky || (s1_q.tiny_c && !s1_q.zero_c));
`endif
                end
            end
        end
    end

endmodule
